// File: rtl/clk_div_multi.sv
// Multi-channel programmable integer clock divider with glitch-free divisor/enable updates.
// Optional CLK_DIV_MULTI_DUTY50_EN: exact 50% duty for odd divisors via a negedge retime flop.
module clk_div_lane #(
  parameter int CW = 8
) (
  input  logic          clk_in,
  input  logic          rst,
  input  logic          en_i,
  input  logic          load_i,
  input  logic [CW-1:0] div_i,
  output logic          clk_o,
  output logic          tick_o,
  output logic          running_o
);
  typedef enum logic {IDLE, RUN} state_e;

  state_e        state_q;
  logic [CW-1:0] shadow_q, cnt_q, act_q;
  logic          clk_q, tick_q;

  logic [CW-1:0] eff, n_eff;
  logic [CW:0]   h_act, cnt_nxt;
  logic          start;

  // A load coinciding with a start or boundary is forwarded straight into the new period.
  assign eff     = load_i ? div_i : shadow_q;
  assign n_eff   = (eff == CW'(1)) ? CW'(2) : eff;
  assign start   = en_i && (eff != '0);
  assign h_act   = ({1'b0, act_q} + (CW+1)'(1)) >> 1;
  assign cnt_nxt = {1'b0, cnt_q} + (CW+1)'(1);

  always_ff @(posedge clk_in) begin
    if (!rst) begin
      state_q  <= IDLE;
      shadow_q <= '0;
      cnt_q    <= '0;
      act_q    <= '0;
      clk_q    <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      if (load_i) shadow_q <= div_i;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= RUN;
            act_q   <= n_eff;
            cnt_q   <= '0;
            clk_q   <= 1'b1;
            tick_q  <= 1'b1;
          end else begin
            clk_q  <= 1'b0;
            tick_q <= 1'b0;
          end
        end
        RUN: begin
          if (cnt_q == act_q - CW'(1)) begin
            if (start) begin
              act_q  <= n_eff;
              cnt_q  <= '0;
              clk_q  <= 1'b1;
              tick_q <= 1'b1;
            end else begin
              state_q <= IDLE;
              cnt_q   <= '0;
              clk_q   <= 1'b0;
              tick_q  <= 1'b0;
            end
          end else begin
            cnt_q  <= cnt_q + CW'(1);
            clk_q  <= (cnt_nxt < h_act);
            tick_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef CLK_DIV_MULTI_DUTY50_EN
  logic neg_q;
  always_ff @(negedge clk_in) begin
    if (!rst) neg_q <= 1'b0;
    else      neg_q <= clk_q;
  end
  // Odd divisors trim half a cycle off the high phase; even ones pass straight through.
  assign clk_o = act_q[0] ? (clk_q & neg_q) : clk_q;
`else
  assign clk_o = clk_q;
`endif

  assign tick_o    = tick_q;
  assign running_o = (state_q == RUN);
endmodule

module clk_div_multi #(
  parameter int NCH = 3,
  parameter int CW  = 8
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic [NCH-1:0]    en,
  input  logic [NCH-1:0]    load,
  input  logic [NCH*CW-1:0] div_i,
  output logic [NCH-1:0]    clk_out,
  output logic [NCH-1:0]    tick,
  output logic [NCH-1:0]    running
);
  for (genvar k = 0; k < NCH; k++) begin : g_ch
    clk_div_lane #(.CW(CW)) u_lane (
      .clk_in    (clk_in),
      .rst       (rst),
      .en_i      (en[k]),
      .load_i    (load[k]),
      .div_i     (div_i[k*CW +: CW]),
      .clk_o     (clk_out[k]),
      .tick_o    (tick[k]),
      .running_o (running[k])
    );
  end
endmodule

// File: tb/tb_clk_div_multi.sv
// Scoreboarded random + directed bench for clk_div_multi against a period-position reference model.
module tb_clk_div_multi;
  localparam int NCH = 3;
  localparam int CW  = 8;

  logic              clk_in = 1'b0;
  logic              rst;
  logic [NCH-1:0]    en, load;
  logic [NCH*CW-1:0] div_i;
  logic [NCH-1:0]    clk_out, tick, running;

  clk_div_multi #(.NCH(NCH), .CW(CW)) dut (
    .clk_in (clk_in),
    .rst    (rst),
    .en     (en),
    .load   (load),
    .div_i  (div_i),
    .clk_out(clk_out),
    .tick   (tick),
    .running(running)
  );

  always #5 clk_in = ~clk_in;

  // Model: each channel is either off or at position pos within a period of length per.
  int          m_sh  [NCH];
  bit          m_act [NCH];
  int          m_pos [NCH];
  int          m_per [NCH];
  logic [3*NCH-1:0] exp_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  task automatic step(input logic r, input logic [NCH-1:0] e, input logic [NCH-1:0] ld,
                      input logic [NCH*CW-1:0] d);
    logic [NCH-1:0] ec, et, er;
    int eff;
    @(negedge clk_in);
    rst = r; en = e; load = ld; div_i = d;
    for (int k = 0; k < NCH; k++) begin
      if (!r) begin
        m_sh[k]  = 0;
        m_act[k] = 1'b0;
      end else begin
        eff = ld[k] ? int'(d[k*CW +: CW]) : m_sh[k];
        if (m_act[k] && (m_pos[k] + 1 < m_per[k])) m_pos[k]++;
        else if (e[k] && eff != 0) begin
          m_act[k] = 1'b1;
          m_pos[k] = 0;
          m_per[k] = (eff == 1) ? 2 : eff;
        end else m_act[k] = 1'b0;
        if (ld[k]) m_sh[k] = int'(d[k*CW +: CW]);
      end
      ec[k] = m_act[k] && (m_pos[k] < (m_per[k] + 1) / 2);
      et[k] = m_act[k] && (m_pos[k] == 0);
      er[k] = m_act[k];
    end
    exp_q.push_back({ec, et, er});
  endtask

  function automatic logic [NCH*CW-1:0] pack(input int d2, input int d1, input int d0);
    return {CW'(d2), CW'(d1), CW'(d0)};
  endfunction

  // Monitor: every cycle the DUT presents a fresh output triple; compare it to the oldest expectation.
  initial begin
    logic [3*NCH-1:0] ex;
    forever begin
      @(posedge clk_in);
      #1;
      cyc++;
      if (exp_q.size() > 0) begin
        ex = exp_q.pop_front();
        n_cmp++;
        if ({clk_out, tick, running} !== ex) begin
          n_bad++;
          $display("FAIL outputs cyc=%0d got clk=%b tick=%b run=%b want clk=%b tick=%b run=%b",
                   cyc, clk_out, tick, running, ex[3*NCH-1 -: NCH], ex[2*NCH-1 -: NCH], ex[NCH-1:0]);
        end
      end
    end
  end

  initial begin
    logic [NCH-1:0]    e, ld;
    logic [NCH*CW-1:0] d;
    rst = 1'b0; en = '0; load = '0; div_i = '0;
    for (int k = 0; k < NCH; k++) begin
      m_sh[k] = 0; m_act[k] = 1'b0; m_pos[k] = 0; m_per[k] = 0;
    end
    repeat (3) step(1'b0, '0, '0, '0);

    // ch0 /4: 1100 repeating
    step(1'b1, 3'b001, 3'b001, pack(0, 0, 4));
    repeat (11) step(1'b1, 3'b001, '0, '0);
    // ch1 /5 alongside
    step(1'b1, 3'b011, 3'b010, pack(0, 5, 0));
    repeat (12) step(1'b1, 3'b011, '0, '0);
    // ch0 reload to 6 mid-period, then 4 then 6 again at various offsets
    step(1'b1, 3'b011, 3'b001, pack(0, 0, 6));
    repeat (9) step(1'b1, 3'b011, '0, '0);
    for (int j = 0; j < 6; j++) begin
      step(1'b1, 3'b011, 3'b001, pack(0, 0, (j % 2) ? 6 : 4));
      repeat (j + 2) step(1'b1, 3'b011, '0, '0);
    end
    // ch0 /8 then drop en, then divisor 0 at the boundary
    step(1'b1, 3'b011, 3'b001, pack(0, 0, 8));
    repeat (10) step(1'b1, 3'b011, '0, '0);
    step(1'b1, 3'b010, '0, '0);
    repeat (14) step(1'b1, 3'b010, '0, '0);
    step(1'b1, 3'b011, 3'b001, pack(0, 0, 8));
    repeat (3) step(1'b1, 3'b011, '0, '0);
    step(1'b1, 3'b011, 3'b001, pack(0, 0, 0));
    repeat (12) step(1'b1, 3'b011, '0, '0);
    // divisor 1 clamps to 2, then 2/3/7 concurrently
    step(1'b1, 3'b001, 3'b001, pack(0, 0, 1));
    repeat (6) step(1'b1, 3'b001, '0, '0);
    step(1'b1, 3'b111, 3'b111, pack(7, 3, 2));
    repeat (30) step(1'b1, 3'b111, '0, '0);
    // reset during a high phase of /6; shadows cleared, so en alone must not restart
    step(1'b1, 3'b111, 3'b001, pack(0, 0, 6));
    repeat (6) step(1'b1, 3'b111, '0, '0);
    step(1'b0, 3'b111, '0, '0);
    repeat (10) step(1'b1, 3'b111, '0, '0);

    // random phase
    e = '0;
    for (int i = 0; i < 4000; i++) begin
      ld = '0;
      d  = '0;
      for (int k = 0; k < NCH; k++) begin
        if ($urandom_range(0, 9) == 0) e[k] = ~e[k];
        if ($urandom_range(0, 7) == 0) begin
          ld[k] = 1'b1;
          d[k*CW +: CW] = ($urandom_range(0, 15) == 0) ? CW'($urandom_range(0, 40))
                                                       : CW'($urandom_range(0, 10));
        end
      end
      step(($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1, e, ld, d);
    end

    step(1'b1, '0, '0, '0);
    @(negedge clk_in);
    @(negedge clk_in);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain got %0d pending want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
